// File: rtl/ifetch_queue_if.sv
// Handshake bundle around the instruction fetch queue: PC path in, memory port
// out/in, decode port out. Signal directions are named from the queue's side.
interface ifetch_queue_if;
  logic [31:0] i_pc;
  logic        i_pc_vld;
  logic        o_pc_rdy;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_gnt;
  logic        i_imem_rvalid;
  logic [31:0] i_imem_rdata;
  logic        i_flush;
  logic        o_instr_vld;
  logic [31:0] o_instr;
  logic [31:0] o_instr_pc;
  logic        i_instr_rdy;

  // The fetch queue itself.
  modport master (
    input  i_pc, i_pc_vld, i_imem_gnt, i_imem_rvalid, i_imem_rdata,
           i_flush, i_instr_rdy,
    output o_pc_rdy, o_imem_req, o_imem_addr, o_instr_vld, o_instr, o_instr_pc
  );

  // PC path, instruction memory and decode around the queue.
  modport slave (
    output i_pc, i_pc_vld, i_imem_gnt, i_imem_rvalid, i_imem_rdata,
           i_flush, i_instr_rdy,
    input  o_pc_rdy, o_imem_req, o_imem_addr, o_instr_vld, o_instr, o_instr_pc
  );
endinterface

// File: rtl/ifetch_queue.sv
// Instruction fetch queue: allocates an entry when a fetch PC is granted to
// instruction memory, fills entries with in-order read responses, and presents
// {pc, instr} pairs to decode from the head. A flush empties the queue and turns
// every still-owed response into a discard credit.
module ifetch_queue #(
  parameter int DEPTH = 4
) (
  input logic            i_clk,
  input logic            i_rst_n,
  ifetch_queue_if.master io_fq
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef logic [PW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  localparam cnt_t          DEPTH_C = cnt_t'(DEPTH);
  localparam logic [CW:0]   DEPTH_O = (CW+1)'(DEPTH);

  logic [31:0]      r_pc    [DEPTH];
  logic [31:0]      r_instr [DEPTH];
  logic [DEPTH-1:0] r_filled;
  ptr_t             r_wr;
  ptr_t             r_fill;
  ptr_t             r_rd;
  cnt_t             r_count;
  cnt_t             r_discard_cnt;

  logic             w_req;
  logic             w_alloc;
  logic             w_fill;
  logic             w_drop;
  logic             w_pop;
  logic             w_head_vld;
  logic [CW:0]      w_occ;
  cnt_t             w_outstanding;

  // Responses still owed to discarded requests occupy memory slots too, so they
  // count against the request budget alongside allocated entries.
  assign w_occ   = {1'b0, r_count} + {1'b0, r_discard_cnt};
  assign w_req   = i_rst_n & io_fq.i_pc_vld & (w_occ < DEPTH_O) & ~io_fq.i_flush;
  assign w_alloc = w_req & io_fq.i_imem_gnt;

  assign w_fill  = io_fq.i_imem_rvalid & (r_discard_cnt == '0) & ~io_fq.i_flush;
  assign w_drop  = io_fq.i_imem_rvalid & (r_discard_cnt != '0) & ~io_fq.i_flush;

  assign w_head_vld = r_filled[r_rd] & (r_count != '0);
  assign w_pop      = w_head_vld & io_fq.i_instr_rdy & ~io_fq.i_flush;

  assign io_fq.o_imem_req  = w_req;
  assign io_fq.o_imem_addr = {io_fq.i_pc[31:2], 2'b00};
  assign io_fq.o_pc_rdy    = w_alloc;
  assign io_fq.o_instr_vld = w_head_vld;
  assign io_fq.o_instr     = r_instr[r_rd];
  assign io_fq.o_instr_pc  = r_pc[r_rd];

  // Allocated-but-unfilled entries; wr==fill is ambiguous only when full, where
  // the head's filled bit tells "all filled" from "none filled".
  always_comb begin
    w_outstanding = cnt_t'(ptr_t'(r_wr - r_fill));
    if ((r_count == DEPTH_C) && (r_wr == r_fill) && !r_filled[r_rd]) begin
      w_outstanding = DEPTH_C;
    end
  end

  // Pointers, occupancy, filled flags and discard credit; flush overrides all.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr          <= '0;
      r_fill        <= '0;
      r_rd          <= '0;
      r_count       <= '0;
      r_discard_cnt <= '0;
      r_filled      <= '0;
    end else if (io_fq.i_flush) begin
      r_wr          <= '0;
      r_fill        <= '0;
      r_rd          <= '0;
      r_count       <= '0;
      r_filled      <= '0;
      r_discard_cnt <= r_discard_cnt + w_outstanding - cnt_t'(io_fq.i_imem_rvalid);
    end else begin
      if (w_alloc) begin
        r_wr           <= r_wr + ptr_t'(1);
        r_filled[r_wr] <= 1'b0;
      end
      if (w_fill) begin
        r_fill           <= r_fill + ptr_t'(1);
        r_filled[r_fill] <= 1'b1;
      end
      if (w_drop) begin
        r_discard_cnt <= r_discard_cnt - cnt_t'(1);
      end
      if (w_pop) begin
        r_rd <= r_rd + ptr_t'(1);
      end
      case ({w_alloc, w_pop})
        2'b10:   r_count <= r_count + cnt_t'(1);
        2'b01:   r_count <= r_count - cnt_t'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry payload; cleared on reset so the head reads as zero out of reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_pc[i]    <= '0;
        r_instr[i] <= '0;
      end
    end else begin
      if (w_alloc) begin
        r_pc[r_wr] <= io_fq.i_pc;
      end
      if (w_fill) begin
        r_instr[r_fill] <= io_fq.i_imem_rdata;
      end
    end
  end

  // A response with nothing allocated and nothing owed means memory broke protocol.
  assert property (@(posedge i_clk) disable iff (!i_rst_n)
    !(io_fq.i_imem_rvalid && (r_count == '0) && (r_discard_cnt == '0)));

endmodule

// File: tb/tb_ifetch_queue.sv
// Bench for ifetch_queue: directed scenarios plus randomized traffic, all checked
// against a queue-level reference model and an in-order memory model.
module tb_ifetch_queue;

  localparam int DEPTH = 4;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    bit          filled;
  } ent_t;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  logic clk = 1'b0;
  logic rst_n;

  ifetch_queue_if fq();

  ifetch_queue #(.DEPTH(DEPTH)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .io_fq   (fq.master)
  );

  always #5 clk = ~clk;

  // reference state
  ent_t  mq[$];
  pend_t pq[$];
  int    disc;
  int    cyc;

  // stimulus knobs
  logic [31:0] pc;
  logic        pc_vld, gnt, rdy, flush, hold_resp;
  int          lat;
  logic        last_acc;

  // observed pops
  logic [31:0] obs_pc[$];
  int          obs_cyc[$];

  int checks;
  int errors;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return ({a[31:2], 2'b00} * 32'h9E37_79B1) ^ 32'h1357_2468;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    if (!hold_resp && pq.size() > 0 && pq[0].due <= cyc) begin
      fq.i_imem_rvalid = 1'b1;
      fq.i_imem_rdata  = memf(pq[0].addr);
    end else begin
      fq.i_imem_rvalid = 1'b0;
      fq.i_imem_rdata  = $urandom;
    end
    fq.i_pc        = pc;
    fq.i_pc_vld    = pc_vld;
    fq.i_imem_gnt  = gnt;
    fq.i_flush     = flush;
    fq.i_instr_rdy = rdy;
  endtask

  task automatic tick();
    logic        exp_req, exp_acc, exp_vld, rv;
    logic [31:0] rd_v;
    drive();
    rv   = fq.i_imem_rvalid;
    rd_v = fq.i_imem_rdata;
    #1;
    exp_req = pc_vld && ((mq.size() + disc) < DEPTH) && !flush;
    exp_acc = exp_req && gnt;
    exp_vld = (mq.size() > 0) && mq[0].filled;
    chk("imem_req", 32'(fq.o_imem_req), 32'(exp_req));
    chk("pc_rdy", 32'(fq.o_pc_rdy), 32'(exp_acc));
    if (exp_req) chk("imem_addr", fq.o_imem_addr, {pc[31:2], 2'b00});
    chk("instr_vld", 32'(fq.o_instr_vld), 32'(exp_vld));
    if (exp_vld) begin
      chk("instr", fq.o_instr, mq[0].instr);
      chk("instr_pc", fq.o_instr_pc, mq[0].pc);
    end
    if (fq.o_instr_vld === 1'b1 && rdy && !flush) begin
      obs_pc.push_back(fq.o_instr_pc);
      obs_cyc.push_back(cyc);
    end
    @(posedge clk);
    if (flush) begin
      int outst;
      outst = 0;
      foreach (mq[i]) if (!mq[i].filled) outst++;
      disc = disc + outst - (rv ? 1 : 0);
      mq.delete();
    end else begin
      if (rv) begin
        if (disc > 0) disc--;
        else begin
          for (int i = 0; i < mq.size(); i++) begin
            if (!mq[i].filled) begin
              mq[i].instr  = rd_v;
              mq[i].filled = 1'b1;
              break;
            end
          end
        end
      end
      if (exp_vld && rdy) void'(mq.pop_front());
      if (exp_acc) mq.push_back('{pc, 32'h0, 1'b0});
    end
    if (rv) void'(pq.pop_front());
    if (exp_acc) pq.push_back('{{pc[31:2], 2'b00}, cyc + lat});
    cyc++;
    last_acc = exp_acc;
    @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    rst_n            = 1'b0;
    fq.i_imem_rvalid = 1'b0;
    fq.i_pc_vld      = 1'b1;
    fq.i_imem_gnt    = 1'b1;
    fq.i_flush       = 1'b0;
    fq.i_instr_rdy   = 1'b1;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      chk("rst_vld", 32'(fq.o_instr_vld), 32'h0);
      chk("rst_pc", fq.o_instr_pc, 32'h0);
      chk("rst_instr", fq.o_instr, 32'h0);
      chk("rst_pc_rdy", 32'(fq.o_pc_rdy), 32'h0);
      chk("rst_req", 32'(fq.o_imem_req), 32'h0);
      @(negedge clk);
    end
    mq.delete();
    pq.delete();
    disc      = 0;
    pc_vld    = 1'b0;
    flush     = 1'b0;
    hold_resp = 1'b0;
    rst_n     = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_list[$];
    int          t0;
    checks = 0; errors = 0; cyc = 0; disc = 0;
    pc = 0; pc_vld = 0; gnt = 1; rdy = 1; flush = 0; hold_resp = 0; lat = 1;
    last_acc = 0;
    rst_n = 1'b0;
    fq.i_pc = 0; fq.i_pc_vld = 0; fq.i_imem_gnt = 0; fq.i_imem_rvalid = 0;
    fq.i_imem_rdata = 0; fq.i_flush = 0; fq.i_instr_rdy = 0;
    @(negedge clk);

    // reset held 3 cycles
    do_reset(3);

    // stream 0,4,8,C at latency 1, one output per cycle
    obs_pc.delete(); obs_cyc.delete();
    gnt = 1; rdy = 1; lat = 1;
    t0 = cyc;
    for (int i = 0; i < 4; i++) begin
      pc = 32'(i * 4); pc_vld = 1; tick();
    end
    pc_vld = 0;
    repeat (4) tick();
    chk("stream_n", 32'(obs_pc.size()), 32'd4);
    for (int i = 0; i < obs_pc.size() && i < 4; i++) begin
      chk("stream_pc", obs_pc[i], 32'(i * 4));
      chk("stream_cyc", 32'(obs_cyc[i]), 32'(t0 + 2 + i));
    end

    // full queue, then backpressure, then drain
    do_reset(1);
    obs_pc.delete(); obs_cyc.delete();
    hold_resp = 1; rdy = 0; gnt = 1;
    for (int i = 0; i < 4; i++) begin
      pc = 32'(i * 4); pc_vld = 1; tick();
    end
    pc = 32'h10; pc_vld = 1;
    drive(); #1;
    chk("full_pc_rdy", 32'(fq.o_pc_rdy), 32'h0);
    tick();
    hold_resp = 0;
    repeat (4) tick();
    for (int i = 0; i < 5; i++) begin
      drive(); #1;
      chk("bp_vld", 32'(fq.o_instr_vld), 32'h1);
      chk("bp_pc", fq.o_instr_pc, 32'h0);
      chk("bp_instr", fq.o_instr, memf(32'h0));
      tick();
    end
    rdy = 1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (last_acc) pc_vld = 0;
    end
    exp_list = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
    chk("drain_n", 32'(obs_pc.size()), 32'd5);
    for (int i = 0; i < obs_pc.size() && i < 5; i++) chk("drain_pc", obs_pc[i], exp_list[i]);

    // flush with 3 outstanding and a response landing in the flush cycle
    do_reset(1);
    obs_pc.delete(); obs_cyc.delete();
    hold_resp = 1; gnt = 1; rdy = 1;
    for (int i = 0; i < 3; i++) begin
      pc = 32'h20 + 32'(i * 4); pc_vld = 1; tick();
    end
    pc_vld = 0; hold_resp = 0; flush = 1;
    tick();
    flush = 0; pc = 32'h100; pc_vld = 1;
    tick();
    pc_vld = 0;
    repeat (8) tick();
    chk("flush_n", 32'(obs_pc.size()), 32'd1);
    if (obs_pc.size() > 0) chk("flush_pc", obs_pc[0], 32'h100);

    // asynchronous reset with 2 filled + 2 outstanding, then restart from 0
    do_reset(1);
    hold_resp = 1; gnt = 1; rdy = 0;
    for (int i = 0; i < 4; i++) begin
      pc = 32'h200 + 32'(i * 4); pc_vld = 1; tick();
    end
    pc_vld = 0; hold_resp = 0;
    repeat (2) tick();
    hold_resp = 1;
    tick();
    #2;
    fq.i_pc_vld = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("async_vld", 32'(fq.o_instr_vld), 32'h0);
    chk("async_pc_rdy", 32'(fq.o_pc_rdy), 32'h0);
    @(negedge clk);
    do_reset(1);
    obs_pc.delete(); obs_cyc.delete();
    rdy = 1; gnt = 1; lat = 1;
    for (int i = 0; i < 2; i++) begin
      pc = 32'(i * 4); pc_vld = 1; tick();
    end
    pc_vld = 0;
    repeat (4) tick();
    chk("restart_n", 32'(obs_pc.size()), 32'd2);
    for (int i = 0; i < obs_pc.size() && i < 2; i++) chk("restart_pc", obs_pc[i], 32'(i * 4));

    // randomized traffic
    pc = 32'h1000; pc_vld = 0;
    for (int n = 0; n < 3000; n++) begin
      flush     = ($urandom % 25) == 0;
      gnt       = ($urandom % 4) != 0;
      rdy       = ($urandom % 3) != 0;
      lat       = 1 + int'($urandom % 3);
      hold_resp = ($urandom % 8) == 0;
      if (!pc_vld) pc_vld = ($urandom % 4) != 0;
      tick();
      if (flush) begin
        pc = $urandom;
        pc[1:0] = (($urandom % 8) == 0) ? 2'($urandom) : 2'b00;
        pc_vld = 0;
      end else if (last_acc) begin
        pc = pc + 32'd4;
        pc_vld = 0;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
